// File: rtl/dnctr_timer.sv
// Loadable down-counting timer: a clk/DIV prescaler generates ticks; each tick
// decrements cnt toward 0, then either wraps back to L or parks in DONE.
module dnctr_timer #(
    parameter int unsigned W      = 3,
    parameter int unsigned L      = (2 ** W) - 1,
    parameter int unsigned DIV    = 4,
    parameter bit          RELOAD = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    output logic [W-1:0] cnt,
    output logic         running,
    output logic         tick,
    output logic         expired
);

    localparam int unsigned    PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  CNT_MAX  = W'(L);
    localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] psc;
    logic [PW-1:0] psc_n;
    logic [W-1:0]  cnt_n;
    logic          tick_n;
    logic          expired_n;
    logic          go;
    logic          hold;

    // start and pause together cancel each other out
    assign go   = start & ~pause;
    assign hold = pause & ~start;

    // Next-state and next-count decode; load outranks tick, tick outranks start/pause
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        psc_n     = psc;
        tick_n    = 1'b0;
        expired_n = 1'b0;
        if (load) begin
            cnt_n = (load_val > CNT_MAX) ? CNT_MAX : load_val;
            psc_n = '0;
            if (state == DONE) begin
                state_n = IDLE;
            end
            // DONE has already been demoted to IDLE, so start resumes with the loaded value
            if (go && (state != RUN)) begin
                state_n = RUN;
            end else if (hold && (state == RUN)) begin
                state_n = PAUSED;
            end
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    if (go) begin
                        state_n = RUN;
                    end
                end
                DONE: begin
                    if (go) begin
                        state_n = RUN;
                        cnt_n   = CNT_MAX;
                        psc_n   = '0;
                    end
                end
                RUN: begin
                    if (psc == PSC_LAST) begin
                        psc_n  = '0;
                        tick_n = 1'b1;
                        if (cnt != '0) begin
                            cnt_n = cnt - W'(1);
                        end else begin
                            expired_n = 1'b1;
                            if (RELOAD) begin
                                cnt_n = CNT_MAX;
                            end else begin
                                state_n = DONE;
                            end
                        end
                        if (hold && (state_n == RUN)) begin
                            state_n = PAUSED;
                        end
                    end else if (hold) begin
                        state_n = PAUSED;
                    end else begin
                        psc_n = psc + PW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, count, prescaler and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= CNT_MAX;
            psc     <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            psc     <= psc_n;
            running <= (state_n == RUN);
            tick    <= tick_n;
            expired <= expired_n;
        end
    end

endmodule

// File: tb/tb_dnctr_timer.sv
// Scoreboard bench for dnctr_timer: one auto-reload and one one-shot instance.
module tb_dnctr_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load1, start1, pause1;
    logic [2:0] load_val1;
    logic [2:0] cnt1;
    logic       running1, tick1, exp1;
    logic       load0, start0, pause0;
    logic [2:0] load_val0;
    logic [2:0] cnt0;
    logic       running0, tick0, exp0;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int s;

    typedef struct {
        int c;
        int e;
        int at;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    dnctr_timer #(.W(3), .L(5), .DIV(4), .RELOAD(1'b1)) u_rl (
        .clk(clk), .reset(reset), .load(load1), .load_val(load_val1),
        .start(start1), .pause(pause1), .cnt(cnt1), .running(running1),
        .tick(tick1), .expired(exp1)
    );

    dnctr_timer #(.W(3), .L(5), .DIV(4), .RELOAD(1'b0)) u_st (
        .clk(clk), .reset(reset), .load(load0), .load_val(load_val0),
        .start(start0), .pause(pause0), .cnt(cnt0), .running(running0),
        .tick(tick0), .expired(exp0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic push1(input int c, input int e, input int at);
        exp_t x;
        x.c = c; x.e = e; x.at = at;
        q1.push_back(x);
    endtask

    task automatic push0(input int c, input int e, input int at);
        exp_t x;
        x.c = c; x.e = e; x.at = at;
        q0.push_back(x);
    endtask

    // Monitor for the auto-reload instance: every tick/expired pulse is scored
    always @(posedge clk) begin
        #1;
        if (tick1 || exp1) begin
            if (q1.size() == 0) begin
                chk("rl_unexpected_tick", 1, 0);
            end else begin
                exp_t x;
                x = q1.pop_front();
                chk("rl_tick_cnt", int'(cnt1), x.c);
                chk("rl_tick_expired", int'(exp1), x.e);
                chk("rl_tick_cycle", cyc, x.at);
            end
        end
    end

    // Monitor for the one-shot instance
    always @(posedge clk) begin
        #1;
        if (tick0 || exp0) begin
            if (q0.size() == 0) begin
                chk("st_unexpected_tick", 1, 0);
            end else begin
                exp_t x;
                x = q0.pop_front();
                chk("st_tick_cnt", int'(cnt0), x.c);
                chk("st_tick_expired", int'(exp0), x.e);
                chk("st_tick_cycle", cyc, x.at);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        load1 = 1'b0; start1 = 1'b0; pause1 = 1'b0; load_val1 = 3'd0;
        load0 = 1'b0; start0 = 1'b0; pause0 = 1'b0; load_val0 = 3'd0;

        // 1: reset values, then idle with no start
        step();
        chk("reset_cnt", int'(cnt1), 5);
        chk("reset_running", int'(running1), 0);
        chk("reset_tick", int'(tick1), 0);
        chk("reset_expired", int'(exp1), 0);
        chk("reset_cnt_oneshot", int'(cnt0), 5);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("idle_cnt", int'(cnt1), 5);
            chk("idle_running", int'(running1), 0);
        end

        // 2: auto-reload full period 5..0 then wrap to 5
        s = cyc + 1;
        push1(4, 0, s + 4);
        push1(3, 0, s + 8);
        push1(2, 0, s + 12);
        push1(1, 0, s + 16);
        push1(0, 0, s + 20);
        push1(5, 1, s + 24);
        push1(4, 0, s + 28);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("run_start_cnt", int'(cnt1), 5);
        while (cyc < s + 29) begin
            step();
            chk("run_running", int'(running1), 1);
        end
        chk("run_queue_drained", q1.size(), 0);
        do_reset();

        // 3: one-shot stops at 0 in DONE, restart reloads
        s = cyc + 1;
        push0(4, 0, s + 4);
        push0(3, 0, s + 8);
        push0(2, 0, s + 12);
        push0(1, 0, s + 16);
        push0(0, 0, s + 20);
        push0(0, 1, s + 24);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_until(s + 24);
        chk("done_expired", int'(exp0), 1);
        chk("done_running", int'(running0), 0);
        chk("done_cnt", int'(cnt0), 0);
        wait_until(s + 35);
        chk("done_hold_cnt", int'(cnt0), 0);
        chk("done_hold_running", int'(running0), 0);
        chk("done_queue_drained", q0.size(), 0);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("restart_cnt", int'(cnt0), 5);
        chk("restart_running", int'(running0), 1);
        do_reset();

        // 4: pause at psc=2 for 10 cycles, resume, then start+pause ignored
        s = cyc + 1;
        push1(4, 0, s + 15);
        push1(3, 0, s + 19);
        push1(2, 0, s + 23);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_until(s + 2);
        pause1 = 1'b1;
        wait_until(s + 12);
        chk("pause_cnt", int'(cnt1), 5);
        chk("pause_running", int'(running1), 0);
        pause1 = 1'b0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("resume_running", int'(running1), 1);
        wait_until(s + 15);
        start1 = 1'b1;
        pause1 = 1'b1;
        wait_until(s + 17);
        start1 = 1'b0;
        pause1 = 1'b0;
        chk("both_high_running", int'(running1), 1);
        wait_until(s + 24);
        chk("pause_queue_drained", q1.size(), 0);
        do_reset();

        // 5: load clipping in IDLE, then load on a tick cycle
        load1 = 1'b1;
        load_val1 = 3'd1;
        step();
        chk("load_1_cnt", int'(cnt1), 1);
        load_val1 = 3'd7;
        step();
        chk("load_clip_cnt", int'(cnt1), 5);
        load1 = 1'b0;
        chk("load_idle_running", int'(running1), 0);
        s = cyc + 1;
        push1(4, 0, s + 4);
        push1(1, 0, s + 12);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_until(s + 7);
        load1 = 1'b1;
        load_val1 = 3'd2;
        step();
        load1 = 1'b0;
        chk("load_tick_cnt", int'(cnt1), 2);
        chk("load_tick_pulse", int'(tick1), 0);
        chk("load_tick_expired", int'(exp1), 0);
        wait_until(s + 13);
        chk("load_queue_drained", q1.size(), 0);
        do_reset();

        // 6: reset while running at cnt=3
        s = cyc + 1;
        push1(4, 0, s + 4);
        push1(3, 0, s + 8);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_until(s + 9);
        chk("pre_reset_cnt", int'(cnt1), 3);
        reset = 1'b1;
        step();
        chk("midreset_cnt", int'(cnt1), 5);
        chk("midreset_running", int'(running1), 0);
        chk("midreset_tick", int'(tick1), 0);
        chk("midreset_expired", int'(exp1), 0);
        reset = 1'b0;
        repeat (6) step();
        chk("midreset_idle_cnt", int'(cnt1), 5);
        chk("final_queue_rl", q1.size(), 0);
        chk("final_queue_st", q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
